key_sched_g: RTL and testbench

KEY_SCHED_G -- requirements
Module: key_sched_g

---
 rtl/key_sched_g.sv | 160 ++++++++++++++++
 tb/tb_key_sched_g.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/key_sched_g.sv
// key_sched_g: AES key-expansion G/H word function.
//   G (mode_h = 0): SubWord(RotWord(inputVal)) ^ {Rcon[roundNum], 24'h0}
//   H (mode_h = 1): SubWord(inputVal)
// The S-box pass is iterative, LANES bytes per cycle, so a request takes 4/LANES cycles.
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   enable        - start request, accepted whenever busy = 0 (including the done cycle)
//   inputVal      - source word, byte0 = [31:24]
//   roundNum      - Rcon index (G mode only)
//   mode_h        - 0 = G function, 1 = H function
//   outputVal     - registered result, held until the next done or reset
//   done          - one-cycle result-valid pulse
//   busy          - computation in flight
//   err           - qualifies done: illegal roundNum in G mode
module key_sched_g #(
  parameter int LANES    = 1,
  parameter int RCON_MAX = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] inputVal,
  input  logic [3:0]  roundNum,
  input  logic        mode_h,
  output logic [31:0] outputVal,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int         GROUPS   = (LANES > 0) ? (4 / LANES) : 1;
  localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("key_sched_g: LANES must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds outside 1..10 have no defined constant and map to 00.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, SUB} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] word_p0;
  logic [3:0]  rnd_p0;
  logic        mode_p0;

  logic        capture;
  logic        illegal;
  logic [7:0]  rcon_byte;
  logic [31:0] sub_word;
  logic [31:0] result;

  assign capture   = (state == IDLE) && enable;
  assign illegal   = !mode_p0 && ((rnd_p0 == 4'd0) || (int'(rnd_p0) > RCON_MAX));
  assign rcon_byte = (mode_p0 || illegal) ? 8'h00 : rcon(rnd_p0);

  // Replace the current lane group's bytes; the rest pass through untouched.
  always_comb begin
    logic [1:0] idx;
    sub_word = word_p0;
    idx      = 2'd0;
    for (int l = 0; l < LANES; l++) begin
      idx = 2'(int'(cnt) * LANES + l);
      sub_word[31 - 8 * idx -: 8] = sbox(word_p0[31 - 8 * idx -: 8]);
    end
  end

  // Rcon is folded in after substitution, when the word is complete.
  assign result = {sub_word[31:24] ^ rcon_byte, sub_word[23:0]};

  // p0: request capture, then in-place substitution of the working word
  always_ff @(posedge clk) begin
    if (capture) begin
      word_p0 <= mode_h ? inputVal : {inputVal[23:0], inputVal[31:24]};
      rnd_p0  <= roundNum;
      mode_p0 <= mode_h;
    end else if (state == SUB) begin
      word_p0 <= sub_word;
    end
  end

  // p1: control FSM and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      outputVal <= 32'h0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SUB;
            cnt   <= 2'd0;
            busy  <= 1'b1;
          end
        end
        SUB: begin
          if (cnt == LAST_GRP) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= illegal;
            outputVal <= result;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched_g.sv
module tb_key_sched_g;

  logic        tb_clk;
  logic [2:0]  rs;
  logic [2:0]  en;
  logic [31:0] inputVal;
  logic [3:0]  roundNum;
  logic        mode_h;
  logic [31:0] ov [3];
  logic [2:0]  dn;
  logic [2:0]  bz;
  logic [2:0]  er;

  int n_pass;
  int n_tot;

  typedef struct {
    logic [31:0] in;
    logic [3:0]  rn;
    logic        mh;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_sched_g #(.LANES(1 << g), .RCON_MAX(10)) u_dut (
      .clk      (tb_clk),
      .rst      (rs[g]),
      .enable   (en[g]),
      .inputVal (inputVal),
      .roundNum (roundNum),
      .mode_h   (mode_h),
      .outputVal(ov[g]),
      .done     (dn[g]),
      .busy     (bz[g]),
      .err      (er[g])
    );
  end

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // One request on DUT k; inputs are scrambled right after capture.
  task automatic run_req(input int k, input vec_t v, input string tag);
    int lat;
    lat = 4 >> k;
    inputVal = v.in; roundNum = v.rn; mode_h = v.mh;
    en[k] = 1'b1;
    step();
    en[k] = 1'b0;
    inputVal = ~v.in; roundNum = 4'd5; mode_h = ~v.mh;
    chk($sformatf("L%0d %s busy0", 1 << k, tag), 32'(bz[k]), 32'd1);
    chk($sformatf("L%0d %s nodone0", 1 << k, tag), 32'(dn[k]), 32'd0);
    for (int i = 1; i < lat; i++) begin
      step();
      chk($sformatf("L%0d %s busy%0d", 1 << k, tag, i), 32'(bz[k]), 32'd1);
      chk($sformatf("L%0d %s nodone%0d", 1 << k, tag, i), 32'(dn[k]), 32'd0);
    end
    step();
    chk($sformatf("L%0d %s done", 1 << k, tag), 32'(dn[k]), 32'd1);
    chk($sformatf("L%0d %s busy_low", 1 << k, tag), 32'(bz[k]), 32'd0);
    chk($sformatf("L%0d %s out", 1 << k, tag), ov[k], v.exp);
    chk($sformatf("L%0d %s err", 1 << k, tag), 32'(er[k]), 32'(v.exp_err));
    step();
    chk($sformatf("L%0d %s done_pulse", 1 << k, tag), 32'(dn[k]), 32'd0);
    chk($sformatf("L%0d %s err_pulse", 1 << k, tag), 32'(er[k]), 32'd0);
    chk($sformatf("L%0d %s out_hold", 1 << k, tag), ov[k], v.exp);
  endtask

  initial begin
    int lat;
    n_pass = 0;
    n_tot  = 0;
    vecs[0] = '{32'hAAAAAAAA, 4'd1,  1'b0, 32'hADACACAC, 1'b0};
    vecs[1] = '{32'hF045FF8B, 4'd2,  1'b0, 32'h6C163D8C, 1'b0};
    vecs[2] = '{32'h00000000, 4'd9,  1'b0, 32'h78636363, 1'b0};
    vecs[3] = '{32'h00000000, 4'd10, 1'b0, 32'h55636363, 1'b0};
    vecs[4] = '{32'h00000000, 4'd0,  1'b1, 32'h63636363, 1'b0};
    vecs[5] = '{32'hAAAAAAAA, 4'd0,  1'b1, 32'hACACACAC, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 4'd0,  1'b0, 32'h16161616, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 4'd11, 1'b0, 32'h16161616, 1'b1};
    vecs[8] = '{32'h01020304, 4'd15, 1'b1, 32'h7C777BF2, 1'b0};
    vecs[9] = '{32'h01020304, 4'd4,  1'b0, 32'h7F7BF27C, 1'b0};

    rs = 3'b111; en = 3'b000;
    inputVal = 32'h0; roundNum = 4'd0; mode_h = 1'b0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("L%0d reset out", 1 << k), ov[k], 32'h0);
      chk($sformatf("L%0d reset done", 1 << k), 32'(dn[k]), 32'd0);
      chk($sformatf("L%0d reset busy", 1 << k), 32'(bz[k]), 32'd0);
      chk($sformatf("L%0d reset err", 1 << k), 32'(er[k]), 32'd0);
    end
    rs = 3'b000;
    step();

    for (int k = 0; k < 3; k++) begin
      lat = 4 >> k;
      for (int i = 0; i < 10; i++) run_req(k, vecs[i], $sformatf("vec%0d", i));

      // Enable while busy is ignored; enable in the done cycle starts the next request.
      inputVal = vecs[1].in; roundNum = vecs[1].rn; mode_h = vecs[1].mh;
      en[k] = 1'b1;
      step();
      inputVal = 32'hFFFFFFFF; roundNum = 4'd0; mode_h = 1'b0;
      step();
      en[k] = 1'b0;
      for (int i = 2; i <= lat; i++) step();
      chk($sformatf("L%0d b2b first done", 1 << k), 32'(dn[k]), 32'd1);
      chk($sformatf("L%0d b2b first out", 1 << k), ov[k], vecs[1].exp);
      chk($sformatf("L%0d b2b first err", 1 << k), 32'(er[k]), 32'd0);
      inputVal = vecs[2].in; roundNum = vecs[2].rn; mode_h = vecs[2].mh;
      en[k] = 1'b1;
      step();
      en[k] = 1'b0;
      chk($sformatf("L%0d b2b second busy", 1 << k), 32'(bz[k]), 32'd1);
      chk($sformatf("L%0d b2b second nodone", 1 << k), 32'(dn[k]), 32'd0);
      for (int i = 1; i < lat; i++) step();
      step();
      chk($sformatf("L%0d b2b second done", 1 << k), 32'(dn[k]), 32'd1);
      chk($sformatf("L%0d b2b second out", 1 << k), ov[k], vecs[2].exp);
      step();
      chk($sformatf("L%0d b2b no extra done", 1 << k), 32'(dn[k]), 32'd0);

      // Reset mid-computation, asserted together with enable.
      inputVal = vecs[0].in; roundNum = vecs[0].rn; mode_h = vecs[0].mh;
      en[k] = 1'b1;
      step();
      rs[k] = 1'b1;
      step();
      rs[k] = 1'b0;
      en[k] = 1'b0;
      chk($sformatf("L%0d rst out", 1 << k), ov[k], 32'h0);
      chk($sformatf("L%0d rst done", 1 << k), 32'(dn[k]), 32'd0);
      chk($sformatf("L%0d rst busy", 1 << k), 32'(bz[k]), 32'd0);
      chk($sformatf("L%0d rst err", 1 << k), 32'(er[k]), 32'd0);
      for (int i = 0; i < lat + 1; i++) begin
        step();
        chk($sformatf("L%0d aborted nodone%0d", 1 << k, i), 32'(dn[k]), 32'd0);
      end
      run_req(k, vecs[0], "after_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
